cci_mpf_prim_rob_mc: RTL

CCI_MPF_PRIM_ROB_MC -- requirements
Module: cci_mpf_prim_rob_mc

---
 rtl/cci_mpf_prim_rob_mc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cci_mpf_prim_rob_mc.sv
// rtl/cci_mpf_prim_rob_mc.sv - multi-channel reorder buffer: in-order alloc, out-of-order fill, in-order drain
// Each channel is a ring of N_ENTRIES slots; payloads live in one shared 2-cycle RAM addressed {ch, idx}.
module cci_mpf_prim_rob_mc #(
  parameter int N_CHANNELS          = 2,
  parameter int N_ENTRIES           = 32,
  parameter int N_DATA_BITS         = 64,
  parameter int N_META_BITS         = 1,
  parameter int MIN_FREE_SLOTS      = 1,
  parameter int MAX_ALLOC_PER_CYCLE = 1,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int IW = $clog2(N_ENTRIES),
  localparam int AW = $clog2(MAX_ALLOC_PER_CYCLE) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AW-1:0]          alloc,
  input  logic [CW-1:0]          allocCh,
  input  logic [N_META_BITS-1:0] allocMeta,
  output logic [N_CHANNELS-1:0]  notFull,
  output logic [IW-1:0]          allocIdx,
  input  logic                   enqData_en,
  input  logic [CW-1:0]          enqDataCh,
  input  logic [IW-1:0]          enqDataIdx,
  input  logic [N_DATA_BITS-1:0] enqData,
  input  logic                   deq_en,
  input  logic [CW-1:0]          deqCh,
  output logic [N_CHANNELS-1:0]  notEmpty,
  output logic                   T2_valid,
  output logic [N_DATA_BITS-1:0] T2_first,
  output logic [N_META_BITS-1:0] T2_firstMeta,
  output logic [CW-1:0]          T2_firstCh
);

  localparam int NW     = N_CHANNELS * N_ENTRIES;
  localparam int LW     = $clog2(NW);
  localparam int PW     = IW + 1;
  localparam int THRESH = (MIN_FREE_SLOTS > MAX_ALLOC_PER_CYCLE) ? MIN_FREE_SLOTS : MAX_ALLOC_PER_CYCLE;

  logic [PW-1:0]          newest_q [N_CHANNELS];
  logic [PW-1:0]          newest_d [N_CHANNELS];
  logic [PW-1:0]          oldest_q [N_CHANNELS];
  logic [PW-1:0]          oldest_d [N_CHANNELS];
  logic [PW-1:0]          occ      [N_CHANNELS];
  logic [NW-1:0]          valid_q;
  logic [NW-1:0]          valid_d;
  logic [N_META_BITS-1:0] meta_q   [NW];
  logic [N_DATA_BITS-1:0] mem      [NW];

  logic [LW-1:0]          alloc_addr [MAX_ALLOC_PER_CYCLE];
  logic [LW-1:0]          enq_addr;
  logic [LW-1:0]          deq_addr;

  logic                   rd_valid_q;
  logic [LW-1:0]          rd_addr_q;
  logic [N_META_BITS-1:0] rd_meta_q;
  logic [CW-1:0]          rd_ch_q;
  logic                   t2_valid_q;
  logic [N_DATA_BITS-1:0] t2_data_q;
  logic [N_META_BITS-1:0] t2_meta_q;
  logic [CW-1:0]          t2_ch_q;

  function automatic logic [LW-1:0] slot_addr(input logic [CW-1:0] ch, input logic [IW-1:0] idx);
    logic [CW+IW-1:0] full;
    full = {ch, idx};
    return full[LW-1:0];
  endfunction

  assign allocIdx = newest_q[allocCh][IW-1:0];
  assign enq_addr = slot_addr(enqDataCh, enqDataIdx);
  assign deq_addr = slot_addr(deqCh, oldest_q[deqCh][IW-1:0]);

  // Flags come from registered pointers only, so a deq frees space for the following cycle.
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      occ[c]      = newest_q[c] - oldest_q[c];
      notFull[c]  = (N_ENTRIES - int'(occ[c])) >= THRESH;
      notEmpty[c] = (occ[c] != '0) && valid_q[slot_addr(CW'(c), oldest_q[c][IW-1:0])];
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_ALLOC_PER_CYCLE; k++)
      alloc_addr[k] = slot_addr(allocCh, newest_q[allocCh][IW-1:0] + IW'(k));
  end

  // Alloc, enq and deq slots are disjoint in any legal cycle, so update order does not matter.
  always_comb begin
    valid_d = valid_q;
    for (int c = 0; c < N_CHANNELS; c++) begin
      newest_d[c] = newest_q[c];
      oldest_d[c] = oldest_q[c];
    end
    newest_d[allocCh] = newest_q[allocCh] + PW'(alloc);
    for (int k = 0; k < MAX_ALLOC_PER_CYCLE; k++)
      if (int'(alloc) > k) valid_d[alloc_addr[k]] = 1'b0;
    if (enqData_en) valid_d[enq_addr] = 1'b1;
    if (deq_en) begin
      oldest_d[deqCh]   = oldest_q[deqCh] + PW'(1);
      valid_d[deq_addr] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        newest_q[c] <= '0;
        oldest_q[c] <= '0;
      end
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      t2_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        newest_q[c] <= newest_d[c];
        oldest_q[c] <= oldest_d[c];
      end
      valid_q    <= valid_d;
      rd_valid_q <= deq_en;
      t2_valid_q <= rd_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (enqData_en) mem[enq_addr] <= enqData;
  end

  // Meta is captured at deq time since the slot may be reallocated before the RAM read completes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_ALLOC_PER_CYCLE; k++)
      if (int'(alloc) > k) meta_q[alloc_addr[k]] <= allocMeta;
    rd_addr_q <= deq_addr;
    rd_meta_q <= meta_q[deq_addr];
    rd_ch_q   <= deqCh;
    t2_data_q <= mem[rd_addr_q];
    t2_meta_q <= rd_meta_q;
    t2_ch_q   <= rd_ch_q;
  end

  assign T2_valid     = t2_valid_q;
  assign T2_first     = t2_data_q;
  assign T2_firstMeta = t2_meta_q;
  assign T2_firstCh   = t2_ch_q;

`ifndef SYNTHESIS
  logic [IW-1:0] enq_off;
  logic          enq_allocated;
  assign enq_off       = enqDataIdx - oldest_q[enqDataCh][IW-1:0];
  assign enq_allocated = {1'b0, enq_off} < occ[enqDataCh];

  always @(posedge clk) begin
    if (reset_n) begin
      if (alloc != '0 && !notFull[allocCh])
        $fatal(1, "alloc on full channel %0d", allocCh);
      if (int'(alloc) > MAX_ALLOC_PER_CYCLE)
        $fatal(1, "alloc count %0d too large", alloc);
      if (enqData_en && !enq_allocated)
        $fatal(1, "enq to unallocated slot ch %0d idx %0d", enqDataCh, enqDataIdx);
      if (enqData_en && valid_q[enq_addr])
        $fatal(1, "enq to already-valid slot ch %0d idx %0d", enqDataCh, enqDataIdx);
      if (deq_en && !notEmpty[deqCh])
        $fatal(1, "deq from channel %0d with no ready entry", deqCh);
    end
  end
`endif

endmodule
